// File: rtl/data_cal_pkg.sv
// data_cal_pkg: shared types and constants for the lane-select adder.
package data_cal_pkg;
    typedef enum logic {EMPTY, LOADED} state_t;
    localparam int SEL_CAPTURE = 0;
    localparam int DEF_LANE_W = 4;
    localparam int DEF_LANES = 4;
    localparam int CNT_W = 8;
endpackage

// File: rtl/data_cal_lane_sum.sv
// data_cal_lane_sum: extracts lane sel and adds it to lane 0; hit flags an in-range sel.
module data_cal_lane_sum #(
    parameter int LANE_W = 4,
    parameter int LANES = 4,
    parameter int SEL_W = 2
) (
    input  logic [LANES*LANE_W-1:0] d,
    input  logic [SEL_W-1:0]        sel,
    output logic [LANE_W:0]         sum,
    output logic                    hit
);
    logic [LANE_W-1:0] lane;
    always_comb begin
        lane = '0;
        hit = 1'b0;
        for (int k = 0; k < LANES; k++)
            if (sel == SEL_W'(k)) begin
                lane = d[k*LANE_W +: LANE_W];
                hit = 1'b1;
            end
        sum = {1'b0, d[LANE_W-1:0]} + {1'b0, lane};
    end
endmodule

// File: rtl/data_cal_mc.sv
// data_cal_mc: capture register, lane0+laneK adder and one-entry valid/ready result register.
// Optional consumed-result counter res_cnt enabled by DATA_CAL_MC_CNT_EN.
module data_cal_mc
    import data_cal_pkg::*;
#(
    parameter int LANE_W = DEF_LANE_W,
    parameter int LANES = DEF_LANES,
    localparam int SEL_W = $clog2(LANES),
    localparam int OUT_W = LANE_W + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*LANE_W-1:0] d,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [OUT_W-1:0]        out,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef DATA_CAL_MC_CNT_EN
    output logic [CNT_W-1:0]        res_cnt,
`endif
    output logic                    err
);
    state_t state, state_n;
    logic [LANES*LANE_W-1:0] d_q;
    logic [OUT_W-1:0] sum;
    logic hit, acc, cap, comp, do_res, err_d;

    data_cal_lane_sum #(.LANE_W(LANE_W), .LANES(LANES), .SEL_W(SEL_W)) u_sum (
        .d(d_q), .sel(sel), .sum(sum), .hit(hit)
    );

    assign in_ready = !out_valid || out_ready;
    assign acc = in_valid && in_ready;
    assign cap = acc && sel == SEL_W'(SEL_CAPTURE);
    assign comp = acc && sel != SEL_W'(SEL_CAPTURE);

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= EMPTY;
        else state <= state_n;

    always_comb state_n = cap ? LOADED : state;

    // Out-of-range lanes behave like computing with nothing captured.
    always_comb begin
        do_res = comp && state == LOADED && hit;
        err_d = comp && !(state == LOADED && hit);
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            d_q <= '0;
            out <= '0;
            out_valid <= 1'b0;
            err <= 1'b0;
        end else begin
            if (cap) d_q <= d;
            if (do_res) out <= sum;
            out_valid <= do_res || (out_valid && !out_ready);
            err <= err_d;
        end

`ifdef DATA_CAL_MC_CNT_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) res_cnt <= '0;
        else if (out_valid && out_ready) res_cnt <= res_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_data_cal_mc.sv
// tb_data_cal_mc: directed self-checking bench for data_cal_mc with default parameters.
module tb_data_cal_mc;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [15:0] d = '0;
    logic [1:0] sel = '0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [4:0] out;
    logic out_valid;
    logic out_ready = 1'b1;
    logic err;
    int checks = 0;
    int errors = 0;
`ifdef DATA_CAL_MC_CNT_EN
    logic [7:0] res_cnt;
`endif

    data_cal_mc dut (
        .clk(clk), .rst(rst), .d(d), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready),
`ifdef DATA_CAL_MC_CNT_EN
        .res_cnt(res_cnt),
`endif
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic v, input logic [1:0] s, input logic [15:0] dv);
        in_valid = v;
        sel = s;
        d = dv;
    endtask

    initial begin
        #3;
        chk("rst_out", 32'(out), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ready", 32'(in_ready), 1);
        #9 rst = 1'b1;
        // compute before any capture
        cmd(1, 2, 16'h0);
        tick();
        chk("empty_err", 32'(err), 1);
        chk("empty_valid", 32'(out_valid), 0);
        cmd(1, 0, 16'h0001);
        tick();
        chk("empty_err_end", 32'(err), 0);
        chk("cap_valid", 32'(out_valid), 0);
        cmd(1, 1, 16'h0);
        tick();
        chk("one_out", 32'(out), 32'h01);
        chk("one_valid", 32'(out_valid), 1);
        cmd(0, 0, 16'h0);
        tick();
        chk("consume_valid", 32'(out_valid), 0);
        chk("consume_out", 32'(out), 32'h01);
        // back-to-back computes
        cmd(1, 0, 16'h3A5F);
        tick();
        cmd(1, 1, 16'h0);
        tick();
        chk("b2b_1", 32'(out), 32'h14);
        chk("b2b_v1", 32'(out_valid), 1);
        cmd(1, 2, 16'hFFFF);
        tick();
        chk("b2b_2", 32'(out), 32'h19);
        chk("b2b_v2", 32'(out_valid), 1);
        cmd(1, 3, 16'h0);
        tick();
        chk("b2b_3", 32'(out), 32'h12);
        chk("b2b_v3", 32'(out_valid), 1);
        cmd(0, 0, 16'h0);
        tick();
        chk("b2b_drain", 32'(out_valid), 0);
        // back-pressure
        cmd(1, 1, 16'h0);
        tick();
        chk("bp_first", 32'(out), 32'h14);
        out_ready = 1'b0;
        cmd(1, 3, 16'h0);
        #1 chk("bp_ready", 32'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_out", 32'(out), 32'h14);
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_no_err", 32'(err), 0);
            chk("bp_ready_low", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 1);
        tick();
        chk("bp_new_out", 32'(out), 32'h12);
        chk("bp_no_bubble", 32'(out_valid), 1);
        cmd(0, 0, 16'h0);
        tick();
        // carry and re-capture
        cmd(1, 0, 16'hFFFF);
        tick();
        cmd(1, 3, 16'h0);
        tick();
        chk("carry", 32'(out), 32'h1E);
        cmd(1, 0, 16'h1111);
        tick();
        chk("recap_valid", 32'(out_valid), 0);
        cmd(1, 3, 16'hFFFF);
        tick();
        chk("recap", 32'(out), 32'h02);
        chk("recap_v", 32'(out_valid), 1);
        // asynchronous reset with a pending result
        cmd(0, 0, 16'h0);
        out_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_out", 32'(out), 0);
        chk("async_valid", 32'(out_valid), 0);
        #1 rst = 1'b1;
        out_ready = 1'b1;
        cmd(1, 1, 16'h0);
        tick();
        chk("post_rst_err", 32'(err), 1);
        chk("post_rst_valid", 32'(out_valid), 0);
        cmd(0, 0, 16'h0);
        tick();
        chk("err_one_cycle", 32'(err), 0);
`ifdef DATA_CAL_MC_CNT_EN
        chk("cnt_start", 32'(res_cnt), 0);
        cmd(1, 0, 16'h3A5F);
        tick();
        out_ready = 1'b0;
        cmd(1, 1, 16'h0);
        tick();
        cmd(0, 0, 16'h0);
        tick();
        tick();
        chk("cnt_stall", 32'(res_cnt), 0);
        out_ready = 1'b1;
        cmd(1, 1, 16'h0);
        for (int i = 0; i < 256; i++) tick();
        cmd(0, 0, 16'h0);
        tick();
        chk("cnt_wrap", 32'(res_cnt), 1);
        chk("cnt_drained", 32'(out_valid), 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
